// File: rtl/perceptron_seq_ctrl.sv
// Perceptron sequencing controller: weight/bias/input storage, one shared signed
// multiplier stepped over all inputs, thresholded output and perceptron learning rule.
module perceptron_seq_ctrl #(
    parameter int N_INPUTS  = 4,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 2*W_WIDTH + $clog2(N_INPUTS+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [W_WIDTH-1:0]   cmd_data,
    output logic                 result_valid,
    output logic                 result_y,
    output logic [ACC_WIDTH-1:0] result_acc,
    output logic                 update_pulse,
    output logic                 busy
);

    localparam int IDX_W = $clog2(N_INPUTS+1);
    localparam int AW    = $clog2(N_INPUTS);
    localparam logic [IDX_W-1:0] N_IDX  = IDX_W'(N_INPUTS);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_INPUTS-1);
    localparam logic [AW-1:0]    LAST_X = AW'(N_INPUTS-1);

    typedef enum logic [1:0] {IDLE, MAC, TRAIN} state_t;
    typedef enum logic [1:0] {OP_LOAD_W = 2'b00, OP_PUSH_X = 2'b01,
                              OP_TRAIN  = 2'b10, OP_CLEAR  = 2'b11} op_t;

    state_t state, state_next;

    logic signed [W_WIDTH-1:0]   w [N_INPUTS];
    logic signed [W_WIDTH-1:0]   x [N_INPUTS];
    logic signed [W_WIDTH-1:0]   bias;
    logic [IDX_W-1:0]            wptr;
    logic [AW-1:0]               xptr;
    logic [IDX_W-1:0]            idx;
    logic [AW-1:0]               idx_a;
    logic signed [ACC_WIDTH-1:0] acc, acc_next;
    logic signed [2*W_WIDTH-1:0] prod;
    logic                        last_y;
    logic                        train_up;

    // Add or subtract in W+1 bits, then clamp to the signed W-bit range.
    function automatic logic signed [W_WIDTH-1:0] sat_step(
        input logic signed [W_WIDTH-1:0] a,
        input logic signed [W_WIDTH-1:0] b,
        input logic                      sub
    );
        logic signed [W_WIDTH:0] s;
        s = sub ? ((W_WIDTH+1)'(a) - (W_WIDTH+1)'(b))
                : ((W_WIDTH+1)'(a) + (W_WIDTH+1)'(b));
        if (s[W_WIDTH] != s[W_WIDTH-1])
            return s[W_WIDTH] ? {1'b1, {(W_WIDTH-1){1'b0}}} : {1'b0, {(W_WIDTH-1){1'b1}}};
        return s[W_WIDTH-1:0];
    endfunction

    assign idx_a    = idx[AW-1:0];
    assign prod     = w[idx_a] * x[idx_a];
    assign acc_next = acc + ACC_WIDTH'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ena) begin
            unique case (state)
                IDLE: if (cmd_valid) begin
                    if (cmd_op == OP_PUSH_X && xptr == LAST_X)
                        state_next = MAC;
                    else if (cmd_op == OP_TRAIN && cmd_data[0] != last_y)
                        state_next = TRAIN;
                end
                MAC:     if (idx == LAST_I) state_next = IDLE;
                TRAIN:   if (idx == N_IDX)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = ena && (state == IDLE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                w[i] <= '0;
                x[i] <= '0;
            end
            bias         <= '0;
            wptr         <= '0;
            xptr         <= '0;
            idx          <= '0;
            acc          <= '0;
            last_y       <= 1'b0;
            train_up     <= 1'b0;
            result_valid <= 1'b0;
            result_y     <= 1'b0;
            result_acc   <= '0;
            update_pulse <= 1'b0;
        end else begin
            // Pulses drop every cycle, even when paused, so they are never stretched.
            result_valid <= 1'b0;
            update_pulse <= 1'b0;
            if (ena) begin
                unique case (state)
                    IDLE: if (cmd_valid) begin
                        unique case (op_t'(cmd_op))
                            OP_LOAD_W: begin
                                if (wptr == N_IDX) begin
                                    bias <= cmd_data;
                                    wptr <= '0;
                                end else begin
                                    w[wptr[AW-1:0]] <= cmd_data;
                                    wptr <= wptr + IDX_W'(1);
                                end
                            end
                            OP_PUSH_X: begin
                                x[xptr] <= cmd_data;
                                if (xptr == LAST_X) begin
                                    xptr <= '0;
                                    acc  <= ACC_WIDTH'(bias);
                                    idx  <= '0;
                                end else begin
                                    xptr <= xptr + AW'(1);
                                end
                            end
                            OP_TRAIN: begin
                                idx      <= '0;
                                train_up <= cmd_data[0];
                            end
                            OP_CLEAR: begin
                                for (int unsigned i = 0; i < N_INPUTS; i++) begin
                                    w[i] <= '0;
                                    x[i] <= '0;
                                end
                                bias   <= '0;
                                wptr   <= '0;
                                xptr   <= '0;
                                last_y <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    MAC: begin
                        acc <= acc_next;
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_I) begin
                            result_acc   <= acc_next;
                            result_y     <= ~acc_next[ACC_WIDTH-1];
                            last_y       <= ~acc_next[ACC_WIDTH-1];
                            result_valid <= 1'b1;
                        end
                    end
                    TRAIN: begin
                        if (idx == N_IDX) begin
                            bias         <= sat_step(bias, W_WIDTH'(1), ~train_up);
                            update_pulse <= 1'b1;
                        end else begin
                            w[idx_a] <= sat_step(w[idx_a], x[idx_a], ~train_up);
                            idx      <= idx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/perceptron_seq_ctrl.md
# perceptron_seq_ctrl

Sequencing controller for the perceptron core behind the `tt_um_perceptron` top. It holds the weight/bias register file and the input vector, and time-multiplexes one signed multiplier over all inputs to produce the dot product and a thresholded output. It also applies the perceptron learning rule on command. A pin adapter in the top drives its command channel from `ui_in`/`uio_in` and maps its results onto `uo_out`.

## Interface
- `N_INPUTS`, default 4: number of inputs, ≥2.
- `W_WIDTH`, default 8: signed width of weights, bias and inputs.
- `ACC_WIDTH`, default 2*W_WIDTH+$clog2(N_INPUTS+1) (19): signed accumulator width. Derived; never overridden.
---
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable. Low freezes all state and forces `cmd_ready`=0.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle if `cmd_valid` is also high.
- `cmd_op`  in  2  00 LOAD_W, 01 PUSH_X, 10 TRAIN, 11 CLEAR.
- `cmd_data`  in  W_WIDTH  operand. Signed for LOAD_W/PUSH_X; bit0 is the target for TRAIN.
- `result_valid`  out  1  one-cycle pulse when a new inference result is available.
- `result_y`  out  1  last classification: 1 iff acc ≥ 0.
- `result_acc`  out  ACC_WIDTH  last signed accumulator value.
- `update_pulse`  out  1  one-cycle pulse when TRAIN actually modified the weights.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Storage:
  - `w[0..N-1]` and `bias`, all W_WIDTH signed.
  - `x[0..N-1]`.
  - Pointers: `wptr` (0..N) and `xptr` (0..N-1).
  - `last_y`.
- States: IDLE, MAC, TRAIN. `cmd_ready` = ena && IDLE.
- LOAD_W: writes `cmd_data` to `w[wptr]`, or to `bias` when `wptr`==N. `wptr` increments and wraps N→0. Stays IDLE.
- PUSH_X: writes `x[xptr]`. `xptr` increments.
  - Any push other than the one at `xptr`==N-1 stays IDLE.
  - The push at `xptr`==N-1 sets `xptr`:=0 and enters MAC with acc := sign-extended `bias` and idx := 0.
- MAC: one step per cycle, acc += w[idx]*x[idx] (full-precision signed product, sign-extended), idx++. After the idx=N-1 step:
  - register `result_acc`.
  - `result_y` = `last_y` = ~acc[MSB].
  - pulse `result_valid`.
  - return to IDLE.
- TRAIN, target t = `cmd_data[0]`:
  - If t == `last_y`: no change, no pulse, stays IDLE.
  - Else enter TRAIN. One weight per cycle for idx 0..N-1: w[idx] := sat(w[idx] ± x[idx]), using + when t=1 and − when t=0.
  - Then one cycle for bias: bias := sat(bias ± 1). Then pulse `update_pulse` and return to IDLE.
  - sat clamps to [−2^(W−1), 2^(W−1)−1].
  - Uses the stored `x`, including a partially refilled vector.
- CLEAR: zeros all weights, `bias`, `x`, `wptr`, `xptr` and `last_y`. It does not change `result_acc` or `result_y`. One cycle; stays IDLE.
- Commands are only accepted in IDLE. While busy, `cmd_valid` is ignored and the requester holds it.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE.
  - All storage and pointers 0.
  - `result_valid`, `result_y`, `result_acc`, `update_pulse` and `busy` all 0.
  - `cmd_ready` = `ena`.
- Inference latency: if the final PUSH_X is accepted at edge k, MAC occupies edges k+1..k+N. `result_valid` is high in the cycle after edge k+N, together with `cmd_ready`=1, so back-to-back commands are legal.
- Train latency: TRAIN accepted at edge k with a mismatch → weight writes at edges k+1..k+N, bias at edge k+N+1. `update_pulse` and `cmd_ready` are high after edge k+N+1.
- `ena` low mid-MAC/TRAIN: the operation pauses and resumes in place when `ena` returns. Pulses are not extended.
- Reset mid-MAC/TRAIN: immediate abort to reset values; no pulses are issued.
- `result_acc` and `result_y` hold their values until the next inference completes.

## Test plan
- Reset with ena=1, cmd_valid=0 → all outputs 0 except `cmd_ready`=1. Same state after asserting `rst_n`=0 in the 2nd MAC cycle.
- LOAD_W 2,−1,3,0,−5 (bias); PUSH_X 1,2,3,4 → `result_valid` exactly 4 edges after the last push; `result_acc`=4, `result_y`=1.
- Same weights; PUSH_X 0,4,0,0 → `result_acc`=−9, `result_y`=0. `cmd_valid` held during MAC is not accepted.
- Then TRAIN t=1 → `update_pulse` 5 edges later; weights 2,3,3,0, bias −4. PUSH_X 0,4,0,0 → acc=8, y=1. TRAIN t=1 again → no pulse, `busy` stays 0.
- Saturation: CLEAR, then LOAD_W 100,−128,0,0,0; PUSH_X 100,100,0,0 → acc=−2800, y=0. TRAIN t=1 → w0=127 (saturated), w1=−28, bias=1.
- `ena` low for 3 cycles mid-MAC → `result_valid` is delayed by exactly 3 cycles and `result_acc` is unchanged from the nominal value.
